// File: rtl/micro_sequencer.sv
// Microprogram sequencer for the MICRO-1 datapath: owns the micro-PC and a small return stack,
// and picks the next control-store address from the current microinstruction's sequencing fields.
module micro_sequencer #(
  parameter int UADDR_W       = 10,
  parameter int OPCODE_W      = 5,
  parameter int STACK_DEPTH   = 4,
  parameter int RESET_VECTOR  = 0,
  parameter int DISPATCH_BASE = 'h100
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2:0]                         seq_op,
  input  logic [2:0]                         seq_cond,
  input  logic [UADDR_W-1:0]                 seq_addr,
  input  logic [15:0]                        ir,
  input  logic                               alu_cout,
  input  logic                               shifter_cout,
  input  logic                               lbus_msb,
  input  logic                               rbus_msb,
  input  logic                               sbus_msb,
  input  logic [15:0]                        abus,
  input  logic                               inbus_valid,
  output logic [UADDR_W-1:0]                 upc,
  output logic                               stall,
  output logic                               fault,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_BR_T     = 3'd2;
  localparam logic [2:0] OP_BR_F     = 3'd3;
  localparam logic [2:0] OP_CALL     = 3'd4;
  localparam logic [2:0] OP_RET      = 3'd5;
  localparam logic [2:0] OP_DISPATCH = 3'd6;
  localparam logic [2:0] OP_WAIT     = 3'd7;

  logic [0:0]          state, state_next;
  logic [UADDR_W-1:0]  upc_next, upc_inc, dispatch_target;
  logic [SP_W-1:0]     sp_next;
  logic                fault_next;
  logic                push_en;
  logic                cond;
  logic [IDX_W-1:0]    push_idx, pop_idx;
  logic [OPCODE_W-1:0] opcode;
  logic [UADDR_W-1:0]  stack_mem [STACK_DEPTH];

  assign opcode   = ir[15 -: OPCODE_W];
  assign upc_inc  = upc + UADDR_W'(1);
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - SP_W'(1));

  // Dispatch entries are four words apart; the sum wraps into the micro-address space.
  assign dispatch_target = UADDR_W'(DISPATCH_BASE + 32'({opcode, 2'b00}));

  always_comb begin
    case (seq_cond)
      3'd0:    cond = 1'b1;
      3'd1:    cond = alu_cout;
      3'd2:    cond = shifter_cout;
      3'd3:    cond = lbus_msb;
      3'd4:    cond = rbus_msb;
      3'd5:    cond = sbus_msb;
      3'd6:    cond = (abus == '0);
      default: cond = inbus_valid;
    endcase
  end

  assign stall = ((state == ST_RUN) && (seq_op == OP_WAIT) && !inbus_valid) ||
                 (state == ST_FAULT);

  always_comb begin
    // NOTE: every output of this block gets a hold value first so no path infers a latch.
    upc_next   = upc;
    sp_next    = sp;
    state_next = state;
    fault_next = fault;
    push_en    = 1'b0;
    if (state == ST_RUN) begin
      case (seq_op)
        OP_NEXT:     upc_next = upc_inc;
        OP_JUMP:     upc_next = seq_addr;
        OP_BR_T:     upc_next = cond ? seq_addr : upc_inc;
        OP_BR_F:     upc_next = cond ? upc_inc : seq_addr;
        OP_CALL: begin
          if (sp < SP_W'(STACK_DEPTH)) begin
            push_en  = 1'b1;
            sp_next  = sp + SP_W'(1);
            upc_next = seq_addr;
          end else begin
            fault_next = 1'b1;
            state_next = ST_FAULT;
          end
        end
        OP_RET: begin
          if (sp != '0) begin
            sp_next  = sp - SP_W'(1);
            upc_next = stack_mem[pop_idx];
          end else begin
            fault_next = 1'b1;
            state_next = ST_FAULT;
          end
        end
        OP_DISPATCH: upc_next = dispatch_target;
        OP_WAIT:     if (inbus_valid) upc_next = upc_inc;
        default:     upc_next = upc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      upc   <= UADDR_W'(RESET_VECTOR);
      sp    <= '0;
      state <= ST_RUN;
      fault <= 1'b0;
    end else begin
      upc   <= upc_next;
      sp    <= sp_next;
      state <= state_next;
      fault <= fault_next;
    end
  end

  // NOTE: stack storage is deliberately not reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_en && !reset) stack_mem[push_idx] <= upc_inc;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: sequencing ops, wrap, dispatch, return stack, faults and WAIT.
module tb_micro_sequencer;

  localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_BR_T = 3'd2, OP_BR_F = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4, OP_RET  = 3'd5, OP_DISP = 3'd6, OP_WAIT = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  seq_op, seq_cond;
  logic [9:0]  seq_addr;
  logic [15:0] ir, abus;
  logic        alu_cout, shifter_cout, lbus_msb, rbus_msb, sbus_msb, inbus_valid;
  logic [9:0]  upc;
  logic        stall, fault;
  logic [2:0]  sp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk(clk), .reset(reset), .seq_op(seq_op), .seq_cond(seq_cond), .seq_addr(seq_addr),
    .ir(ir), .alu_cout(alu_cout), .shifter_cout(shifter_cout), .lbus_msb(lbus_msb),
    .rbus_msb(rbus_msb), .sbus_msb(sbus_msb), .abus(abus), .inbus_valid(inbus_valid),
    .upc(upc), .stall(stall), .fault(fault), .sp(sp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] cnd, input logic [9:0] addr);
    seq_op   = op;
    seq_cond = cnd;
    seq_addr = addr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [2:0] op, input logic [2:0] cnd, input logic [9:0] addr);
    drive(op, cnd, addr);
    tick();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(OP_NEXT, 3'd0, 10'h000);
    tick();
    reset = 1'b0;
  endtask

  // Drive exactly one status source for condition c; c==6 selects the abus zero test.
  task automatic set_status(input int c, input logic v);
    alu_cout = 1'b0; shifter_cout = 1'b0; lbus_msb = 1'b0; rbus_msb = 1'b0;
    sbus_msb = 1'b0; inbus_valid = 1'b0; abus = 16'h0001;
    case (c)
      1: alu_cout     = v;
      2: shifter_cout = v;
      3: lbus_msb     = v;
      4: rbus_msb     = v;
      5: sbus_msb     = v;
      6: abus         = v ? 16'h0000 : 16'h0001;
      7: inbus_valid  = v;
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b1;
    ir    = 16'h0000;
    set_status(0, 1'b0);
    drive(OP_NEXT, 3'd0, 10'h000);
    tick();
    tick();
    reset = 1'b0;

    // Reset state and simple increment
    check("reset_upc", upc, 10'h000);
    check("reset_sp", sp, 3'd0);
    check("reset_fault", fault, 1'b0);
    check("reset_stall", stall, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(OP_NEXT, 3'd0, 10'h3FF);
      check($sformatf("next_%0d", i), upc, 32'(i));
    end

    // Reset overrides a pending WAIT; stall then follows whatever op is presented
    drive(OP_WAIT, 3'd0, 10'h000);
    check("wait_stall_pre_reset", stall, 1'b1);
    reset = 1'b1;
    tick();
    check("reset_in_wait_upc", upc, 10'h000);
    check("reset_in_wait_stall", stall, 1'b1);
    drive(OP_NEXT, 3'd0, 10'h000);
    check("reset_new_op_stall", stall, 1'b0);
    reset = 1'b0;

    // Wrap, jump and the branch conditions
    step(OP_JUMP, 3'd1, 10'h3FF);
    check("jump_3ff", upc, 10'h3FF);
    step(OP_NEXT, 3'd0, 10'h000);
    check("wrap", upc, 10'h000);
    step(OP_JUMP, 3'd0, 10'h2A0);
    check("jump_2a0", upc, 10'h2A0);
    set_status(1, 1'b1);
    step(OP_BR_T, 3'd1, 10'h050);
    check("br_t_cout1", upc, 10'h050);
    set_status(1, 1'b0);
    step(OP_BR_T, 3'd1, 10'h0AA);
    check("br_t_cout0", upc, 10'h051);
    set_status(6, 1'b1);
    step(OP_BR_F, 3'd6, 10'h123);
    check("br_f_abus0", upc, 10'h052);
    set_status(6, 1'b0);
    step(OP_BR_F, 3'd6, 10'h123);
    check("br_f_abus1", upc, 10'h123);
    set_status(0, 1'b0);
    step(OP_BR_T, 3'd0, 10'h077);
    check("br_t_true", upc, 10'h077);
    for (int c = 1; c <= 7; c++) begin
      if (c != 6) begin
        set_status(c, 1'b1);
        step(OP_BR_T, 3'(c), 10'(32'h200 + c));
        check($sformatf("cond%0d_hi", c), upc, 32'h200 + c);
        set_status(c, 1'b0);
        step(OP_BR_T, 3'(c), 10'h3F0);
        check($sformatf("cond%0d_lo", c), upc, 32'h201 + c);
      end
    end
    set_status(0, 1'b0);

    // Opcode dispatch: ir=A800 gives opcode 0x15
    ir = 16'hA800;
    step(OP_DISP, 3'd0, 10'h3FF);
    check("dispatch", upc, 10'h154);

    // Nested calls and returns
    do_reset();
    step(OP_JUMP, 3'd0, 10'h010);
    for (int i = 1; i <= 4; i++) begin
      step(OP_CALL, 3'd0, 10'(32'h010 * (i + 1)));
      check($sformatf("call%0d_upc", i), upc, 32'h010 * (i + 1));
      check($sformatf("call%0d_sp", i), sp, 32'(i));
    end
    for (int i = 4; i >= 1; i--) begin
      step(OP_RET, 3'd0, 10'h3FF);
      check($sformatf("ret%0d_upc", i), upc, 32'h010 * i + 1);
      check($sformatf("ret%0d_sp", i), sp, 32'(i - 1));
    end

    // Overflow: fifth call faults and freezes everything
    for (int i = 1; i <= 4; i++) step(OP_CALL, 3'd0, 10'(32'h010 * (i + 1)));
    check("refill_sp", sp, 3'd4);
    step(OP_CALL, 3'd0, 10'h060);
    check("ovf_fault", fault, 1'b1);
    check("ovf_stall", stall, 1'b1);
    check("ovf_upc", upc, 10'h050);
    check("ovf_sp", sp, 3'd4);
    for (int i = 0; i < 10; i++) begin
      step(3'(i % 8), 3'd0, 10'h111);
      check($sformatf("frozen_upc_%0d", i), upc, 10'h050);
      check($sformatf("frozen_stall_%0d", i), stall, 1'b1);
    end
    check("frozen_sp", sp, 3'd4);
    do_reset();
    check("reset_clears_fault", fault, 1'b0);
    check("reset_clears_sp", sp, 3'd0);

    // Underflow
    step(OP_RET, 3'd0, 10'h3FF);
    check("unf_fault", fault, 1'b1);
    check("unf_upc", upc, 10'h000);
    check("unf_sp", sp, 3'd0);
    do_reset();
    check("reset_after_unf", fault, 1'b0);

    // WAIT holds until inbus_valid
    step(OP_JUMP, 3'd0, 10'h123);
    for (int i = 0; i < 7; i++) begin
      drive(OP_WAIT, 3'd0, 10'h3FF);
      check($sformatf("wait_stall_%0d", i), stall, 1'b1);
      tick();
      check($sformatf("wait_upc_%0d", i), upc, 10'h123);
    end
    inbus_valid = 1'b1;
    drive(OP_WAIT, 3'd0, 10'h3FF);
    check("wait_valid_stall", stall, 1'b0);
    tick();
    check("wait_valid_upc", upc, 10'h124);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
